// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store encodings and the LSU state type.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_CAPTURE,
    S_RESP
  } lsu_state_e;

endpackage

// File: rtl/lsu_align_check.sv
// Combinational legality decode for one load/store request.
module lsu_align_check
  import rv32i_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       we,
  input  logic [1:0] addr_lo,
  output logic       err
);

  logic w_bad_f3;
  logic w_bad_st;
  logic w_misalign;

  always_comb begin
    // 011, 110, 111 have no load/store meaning
    w_bad_f3   = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    // unsigned variants exist only for loads
    w_bad_st   = we && funct3[2];
    w_misalign = ((funct3[1:0] == SZ_H) && addr_lo[0]) ||
                 ((funct3[1:0] == SZ_W) && (addr_lo != 2'b00));
    err        = w_bad_f3 || w_bad_st || w_misalign;
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-request load/store unit: legality check, one memory access, held response.
module load_store_unit
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_size,
  output logic        mem_is_signed,
  input  logic [31:0] mem_rdata
);

  lsu_state_e r_state;
  logic       r_we;
  logic       w_err;

  lsu_align_check u_align (
    .funct3  (req_funct3),
    .we      (req_we),
    .addr_lo (req_addr[1:0]),
    .err     (w_err)
  );

  // gated by rst so the core sees no ready while reset is held
  assign req_ready = rst && (r_state == S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_we          <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_size      <= '0;
      mem_is_signed <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            if (w_err) begin
              r_state   <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              r_state       <= S_ACCESS;
              r_we          <= req_we;
              mem_addr      <= req_addr;
              mem_wdata     <= req_wdata;
              mem_size      <= req_funct3[1:0];
              mem_is_signed <= ~req_we & ~req_funct3[2];
              mem_write     <= req_we;
              mem_read      <= ~req_we;
            end
          end
        end
        S_ACCESS: begin
          mem_write <= 1'b0;
          if (r_we) begin
            r_state   <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
          end else begin
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          // memory returns data already extended to 32 bits
          mem_read  <= 1'b0;
          rsp_rdata <= mem_rdata;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          r_state   <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a small byte-addressed memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_is_signed;
  logic [31:0] mem_rdata;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_is_signed(mem_is_signed), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // byte memory, little-endian, extends loads like the real data memory
  logic [7:0] m [0:255];
  logic [7:0] ma;
  assign ma = mem_addr[7:0];

  initial for (int i = 0; i < 256; i++) m[i] = 8'h00;

  always @(posedge clk) begin
    if (mem_write) begin
      m[ma] <= mem_wdata[7:0];
      if (mem_size != 2'b00) m[ma + 8'd1] <= mem_wdata[15:8];
      if (mem_size == 2'b10) begin
        m[ma + 8'd2] <= mem_wdata[23:16];
        m[ma + 8'd3] <= mem_wdata[31:24];
      end
    end
  end

  always_comb begin
    mem_rdata = {m[ma + 8'd3], m[ma + 8'd2], m[ma + 8'd1], m[ma]};
    if (mem_size == 2'b00)
      mem_rdata = mem_is_signed ? {{24{m[ma][7]}}, m[ma]} : {24'd0, m[ma]};
    else if (mem_size == 2'b01)
      mem_rdata = mem_is_signed ? {{16{m[ma + 8'd1][7]}}, m[ma + 8'd1], m[ma]}
                                : {16'd0, m[ma + 8'd1], m[ma]};
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwr;
    int          nrd;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t q[$];

  function automatic exp_t ex(input logic [31:0] rdata, input logic err, input int lat,
                              input int nwr, input int nrd, input logic [1:0] size,
                              input logic sgn, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    e.rdata = rdata; e.err = err; e.lat = lat; e.nwr = nwr; e.nrd = nrd;
    e.size = size; e.sgn = sgn; e.addr = addr; e.wdata = wdata;
    return e;
  endfunction

  // monitor: tracks accept time and strobes, pops the scoreboard on each response
  int          acc, nwr, nrd;
  bit          pend, seen;
  logic [31:0] s_rdata, saddr, swdata;
  logic        s_err, ssgn;
  logic [1:0]  ssize;
  exp_t        e;

  always @(negedge clk) begin
    if (!rst) begin
      pend = 0;
      seen = 0;
    end else begin
      compared++;
      if ((mem_read && mem_write) || (rsp_valid && (req_ready || mem_read || mem_write))) begin
        mismatched++;
        $display("FAIL invariant: rd=%b wr=%b rsp_valid=%b req_ready=%b expected no overlap",
                 mem_read, mem_write, rsp_valid, req_ready);
      end
      if (req_valid && req_ready) begin
        acc = cyc + 1; pend = 1; seen = 0; nwr = 0; nrd = 0;
      end
      if (mem_write) begin
        nwr++; ssize = mem_size; ssgn = mem_is_signed; saddr = mem_addr; swdata = mem_wdata;
      end
      if (mem_read) begin
        nrd++; ssize = mem_size; ssgn = mem_is_signed; saddr = mem_addr;
      end
      if (rsp_valid) begin
        if (!seen) begin
          if (!pend || q.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
          end else begin
            e = q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            chk("latency", 32'(cyc - acc + 1), 32'(e.lat));
            chk("write_cycles", 32'(nwr), 32'(e.nwr));
            chk("read_cycles", 32'(nrd), 32'(e.nrd));
            if (!e.err) begin
              chk("mem_size", {30'd0, ssize}, {30'd0, e.size});
              chk("mem_is_signed", {31'd0, ssgn}, {31'd0, e.sgn});
              chk("mem_addr", saddr, e.addr);
            end
            if (e.nwr != 0) chk("mem_wdata", swdata, e.wdata);
          end
          seen = 1; s_rdata = rsp_rdata; s_err = rsp_err;
        end else begin
          chk("hold_rdata", rsp_rdata, s_rdata);
          chk("hold_err", {31'd0, rsp_err}, {31'd0, s_err});
        end
        if (rsp_ready) begin pend = 0; seen = 0; end
      end
    end
  end

  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input exp_t ev, input int hold);
    int n;
    q.push_back(ev);
    @(posedge clk); #1;
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    req_valid = 1'b1; rsp_ready = (hold == 0);
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) begin
      compared++; mismatched++;
      $display("FAIL accept_timeout: got no req_ready expected ready within 20 cycles");
      req_valid = 1'b0; rsp_ready = 1'b1;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) begin
      compared++; mismatched++;
      $display("FAIL rsp_timeout: got no rsp_valid expected response within 20 cycles");
      rsp_ready = 1'b1;
      return;
    end
    repeat (hold) begin
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("done_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("done_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                    input logic [1:0] sz);
    run(1'b1, f3, a, wd, ex(32'd0, 1'b0, 2, 1, 0, sz, 1'b0, a, wd), 0);
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd,
                    input logic [1:0] sz, input logic sgn, input int hold);
    run(1'b0, f3, a, 32'd0, ex(rd, 1'b0, 3, 0, 2, sz, sgn, a, 32'd0), hold);
  endtask

  task automatic bad(input logic we, input logic [2:0] f3, input logic [31:0] a);
    run(we, f3, a, 32'hFFFF_FFFF, ex(32'd0, 1'b1, 1, 0, 0, 2'b00, 1'b0, 32'd0, 32'd0), 0);
  endtask

  initial begin
    #2;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("rel_req_ready", {31'd0, req_ready}, 32'd1);

    st(3'b000, 32'd10, 32'h0000_00AA, 2'b00);               // SB
    ld(3'b000, 32'd10, 32'hFFFF_FFAA, 2'b00, 1'b1, 0);      // LB
    st(3'b001, 32'd20, 32'h0000_BEEF, 2'b01);               // SH
    ld(3'b101, 32'd20, 32'h0000_BEEF, 2'b01, 1'b0, 0);      // LHU
    ld(3'b001, 32'd20, 32'hFFFF_BEEF, 2'b01, 1'b1, 0);      // LH
    ld(3'b100, 32'd10, 32'h0000_00AA, 2'b00, 1'b0, 0);      // LBU
    st(3'b010, 32'd100, 32'hDEAD_BEEF, 2'b10);              // SW
    ld(3'b010, 32'd100, 32'hDEAD_BEEF, 2'b10, 1'b1, 0);     // LW
    bad(1'b0, 3'b010, 32'd102);                             // LW misaligned
    bad(1'b1, 3'b001, 32'd21);                              // SH misaligned
    bad(1'b1, 3'b100, 32'd8);                               // store with BU
    bad(1'b0, 3'b011, 32'd0);
    bad(1'b0, 3'b110, 32'd4);
    st(3'b010, 32'hFFFF_FFFC, 32'h1234_5678, 2'b10);        // top-of-space word
    ld(3'b010, 32'hFFFF_FFFC, 32'h1234_5678, 2'b10, 1'b1, 4);

    // reset while the load sits in CAPTURE
    @(posedge clk); #1;
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'd100; req_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("capture_mem_read", {31'd0, mem_read}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (4) begin
      @(posedge clk); #1;
      chk("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    ld(3'b100, 32'd10, 32'h0000_00AA, 2'b00, 1'b0, 0);

    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      compared++; mismatched++;
      $display("FAIL scoreboard_left: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
